// File: rtl/wb_snoop_responder.sv
// Snoop responder: captures locally written words in a small fully-associative
// dirty table and answers snoop reads from the Wishbone snoop arbiter.
module wb_snoop_responder #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int num_entries = 4
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_n_i,
    input  logic [aw-1:0]                      snoop_adr_i,
    input  logic                               snoop_type_i,
    output logic                               snoop_ack_o,
    output logic                               snoop_hit_o,
    output logic [dw-1:0]                      snoop_dat_o,
    input  logic                               st_valid_i,
    input  logic [aw-1:0]                      st_adr_i,
    input  logic [dw-1:0]                      st_dat_i,
    input  logic [3:0]                         st_sel_i,
    output logic                               st_ready_o,
    input  logic                               inv_valid_i,
    input  logic [aw-1:0]                      inv_adr_i,
    output logic [$clog2(num_entries+1)-1:0]   occupancy_o
);

    localparam int tw = aw - 2;
    localparam int ow = $clog2(num_entries + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                 state_r;
    logic [tw-1:0]          snp_tag_r;
    logic                   hit_r;
    logic [dw-1:0]          dat_r;

    logic [num_entries-1:0] valid_r;
    logic [tw-1:0]          tag_r   [num_entries];
    logic [dw-1:0]          data_r  [num_entries];
    logic [3:0]             bmask_r [num_entries];

    logic [tw-1:0]          st_tag_s;
    logic [tw-1:0]          inv_tag_s;
    logic [num_entries-1:0] st_match_s;
    logic [num_entries-1:0] inv_match_s;
    logic [num_entries-1:0] alloc_s;
    logic                   free_any_s;
    logic                   st_hit_s;
    logic                   st_do_s;
    logic                   inv_same_s;
    logic                   snp_hit_s;
    logic [dw-1:0]          snp_dat_s;
    logic [ow-1:0]          occ_cnt_s;
    logic                   unused_adr_bits_s;

    // Expand byte enables to a bit mask over the data word.
    function automatic logic [dw-1:0] byte_mask(input logic [3:0] sel);
        logic [dw-1:0] m;
        m = '0;
        for (int b = 0; b < dw / 8; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Replace the selected bytes of an existing word with new data.
    function automatic logic [dw-1:0] merge_bytes(input logic [dw-1:0] old_w,
                                                  input logic [dw-1:0] new_w,
                                                  input logic [3:0]    sel);
        logic [dw-1:0] m;
        m = byte_mask(sel);
        return (old_w & ~m) | (new_w & m);
    endfunction

    assign st_tag_s          = st_adr_i[aw-1:2];
    assign inv_tag_s         = inv_adr_i[aw-1:2];
    assign unused_adr_bits_s = ^{snoop_adr_i[1:0], st_adr_i[1:0], inv_adr_i[1:0]};

    // Tag matching for store/invalidate and lowest-index free slot selection.
    always_comb begin
        st_match_s  = '0;
        inv_match_s = '0;
        alloc_s     = '0;
        free_any_s  = 1'b0;
        for (int i = 0; i < num_entries; i++) begin
            st_match_s[i]  = valid_r[i] && (tag_r[i] == st_tag_s);
            inv_match_s[i] = valid_r[i] && (tag_r[i] == inv_tag_s);
            alloc_s[i]     = !valid_r[i] && !free_any_s;
            free_any_s     = free_any_s | !valid_r[i];
        end
    end

    assign st_hit_s   = |st_match_s;
    assign st_ready_o = (state_r == IDLE) && (st_hit_s || free_any_s);
    assign st_do_s    = st_valid_i && st_ready_o && (st_sel_i != 4'h0);
    // A store and an invalidate to the same word in one cycle: the store rebuilds the entry.
    assign inv_same_s = inv_valid_i && st_do_s && (inv_tag_s == st_tag_s);

    // Snoop lookup against fully written entries only.
    always_comb begin
        snp_hit_s = 1'b0;
        snp_dat_s = '0;
        for (int i = 0; i < num_entries; i++) begin
            if (valid_r[i] && (tag_r[i] == snp_tag_r) && (bmask_r[i] == 4'hF)) begin
                snp_hit_s = 1'b1;
                snp_dat_s = snp_dat_s | data_r[i];
            end else begin
                snp_dat_s = snp_dat_s;
            end
        end
    end

    // Population count of valid entries, clamped to table depth.
    always_comb begin
        occ_cnt_s = '0;
        for (int i = 0; i < num_entries; i++) begin
            occ_cnt_s = occ_cnt_s + ow'(valid_r[i]);
        end
        if (occ_cnt_s > ow'(num_entries)) begin
            occ_cnt_s = ow'(num_entries);
        end else begin
            occ_cnt_s = occ_cnt_s;
        end
    end

    // Dirty table update: store merge/allocate, then invalidate.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            valid_r <= '0;
            for (int i = 0; i < num_entries; i++) begin
                tag_r[i]   <= '0;
                data_r[i]  <= '0;
                bmask_r[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < num_entries; i++) begin
                if (st_do_s && st_match_s[i]) begin
                    if (inv_same_s) begin
                        data_r[i]  <= st_dat_i & byte_mask(st_sel_i);
                        bmask_r[i] <= st_sel_i;
                    end else begin
                        data_r[i]  <= merge_bytes(data_r[i], st_dat_i, st_sel_i);
                        bmask_r[i] <= bmask_r[i] | st_sel_i;
                    end
                end else if (st_do_s && !st_hit_s && alloc_s[i]) begin
                    valid_r[i] <= 1'b1;
                    tag_r[i]   <= st_tag_s;
                    data_r[i]  <= st_dat_i & byte_mask(st_sel_i);
                    bmask_r[i] <= st_sel_i;
                end else if (inv_valid_i && inv_match_s[i]) begin
                    valid_r[i] <= 1'b0;
                    bmask_r[i] <= 4'h0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Occupancy lags the table by one cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            occupancy_o <= '0;
        end else begin
            occupancy_o <= occ_cnt_s;
        end
    end

    // Snoop FSM with registered response outputs.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r     <= IDLE;
            snp_tag_r   <= '0;
            hit_r       <= 1'b0;
            dat_r       <= '0;
            snoop_ack_o <= 1'b0;
            snoop_hit_o <= 1'b0;
            snoop_dat_o <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    snoop_ack_o <= 1'b0;
                    snoop_hit_o <= 1'b0;
                    snoop_dat_o <= '0;
                    if (snoop_type_i) begin
                        snp_tag_r <= snoop_adr_i[aw-1:2];
                        state_r   <= LOOKUP;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                LOOKUP: begin
                    hit_r <= snp_hit_s;
                    dat_r <= snp_dat_s;
                    if (snoop_type_i) begin
                        state_r <= RESPOND;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RESPOND: begin
                    if (snoop_type_i) begin
                        snoop_ack_o <= 1'b1;
                        snoop_hit_o <= hit_r;
                        snoop_dat_o <= dat_r;
                    end else begin
                        snoop_ack_o <= 1'b0;
                        snoop_hit_o <= 1'b0;
                        snoop_dat_o <= '0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    snoop_ack_o <= 1'b0;
                    snoop_hit_o <= 1'b0;
                    snoop_dat_o <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench for wb_snoop_responder with hand-computed expectations.
module tb_wb_snoop_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] snoop_adr;
    logic        snoop_type;
    logic        snoop_ack;
    logic        snoop_hit;
    logic [31:0] snoop_dat;
    logic        st_valid;
    logic [31:0] st_adr;
    logic [31:0] st_dat;
    logic [3:0]  st_sel;
    logic        st_ready;
    logic        inv_valid;
    logic [31:0] inv_adr;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    wb_snoop_responder #(.dw(32), .aw(32), .num_entries(4)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n_i   (rst_n),
        .snoop_adr_i  (snoop_adr),
        .snoop_type_i (snoop_type),
        .snoop_ack_o  (snoop_ack),
        .snoop_hit_o  (snoop_hit),
        .snoop_dat_o  (snoop_dat),
        .st_valid_i   (st_valid),
        .st_adr_i     (st_adr),
        .st_dat_i     (st_dat),
        .st_sel_i     (st_sel),
        .st_ready_o   (st_ready),
        .inv_valid_i  (inv_valid),
        .inv_adr_i    (inv_adr),
        .occupancy_o  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        st_valid = 1'b1; st_adr = a; st_dat = d; st_sel = s;
        step();
        st_valid = 1'b0;
    endtask

    task automatic inval(input logic [31:0] a);
        inv_valid = 1'b1; inv_adr = a;
        step();
        inv_valid = 1'b0;
    endtask

    // Leaves the FSM in RESPOND with the ack visible.
    task automatic snoop_start(input logic [31:0] a);
        snoop_type = 1'b1; snoop_adr = a;
        step(); step(); step();
    endtask

    task automatic snoop_end();
        snoop_type = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; snoop_adr = 32'h0; snoop_type = 1'b0;
        st_valid = 1'b0; st_adr = 32'h0; st_dat = 32'h0; st_sel = 4'h0;
        inv_valid = 1'b0; inv_adr = 32'h0;
        #3;
        chk("rst_ack", snoop_ack, 1'b0);
        chk("rst_hit", snoop_hit, 1'b0);
        chk("rst_dat", snoop_dat, 32'h0);
        chk("rst_occ", occupancy, 3'd0);
        #10 rst_n = 1'b1;
        step();
        chk("rdy_after_rst", st_ready, 1'b1);

        // Full-word store then snoop hit with exact latency
        store(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        snoop_type = 1'b1; snoop_adr = 32'h0000_1000;
        step();
        chk("lat_edge_n", snoop_ack, 1'b0);
        step();
        chk("lat_edge_n1", snoop_ack, 1'b0);
        step();
        chk("lat_edge_n2_ack", snoop_ack, 1'b1);
        chk("t1_hit", snoop_hit, 1'b1);
        chk("t1_dat", snoop_dat, 32'hDEAD_BEEF);
        snoop_adr = 32'h0000_2000;
        step();
        chk("t1_hold_ack", snoop_ack, 1'b1);
        chk("t1_hold_dat", snoop_dat, 32'hDEAD_BEEF);
        chk("t1_occ", occupancy, 3'd1);
        snoop_end();
        chk("t1_drop_ack", snoop_ack, 1'b0);
        chk("t1_drop_dat", snoop_dat, 32'h0);

        // Partial store misses, merged word hits
        inval(32'h0000_1000);
        store(32'h0000_2000, 32'hAABB_CCDD, 4'h3);
        snoop_start(32'h0000_2000);
        chk("t2_part_ack", snoop_ack, 1'b1);
        chk("t2_part_hit", snoop_hit, 1'b0);
        chk("t2_part_dat", snoop_dat, 32'h0);
        snoop_end();
        store(32'h0000_2000, 32'hAABB_CCDD, 4'hC);
        snoop_start(32'h0000_2000);
        chk("t2_merge_hit", snoop_hit, 1'b1);
        chk("t2_merge_dat", snoop_dat, 32'hAABB_CCDD);
        chk("t2_occ", occupancy, 3'd1);
        snoop_end();

        // Fill the table, fifth store stalls until a slot frees
        inval(32'h0000_2000);
        store(32'h0000_3000, 32'hA0A1_A2A3, 4'hF);
        store(32'h0000_3004, 32'hB0B1_B2B3, 4'hF);
        store(32'h0000_3008, 32'hC0C1_C2C3, 4'hF);
        store(32'h0000_300C, 32'hD0D1_D2D3, 4'hF);
        step();
        chk("t3_occ_full", occupancy, 3'd4);
        st_valid = 1'b1; st_adr = 32'h0000_4000; st_dat = 32'hE0E1_E2E3; st_sel = 4'hF;
        #1;
        chk("t3_full_rdy", st_ready, 1'b0);
        inv_valid = 1'b1; inv_adr = 32'h0000_3008;
        step();
        inv_valid = 1'b0;
        #1;
        chk("t3_freed_rdy", st_ready, 1'b1);
        step();
        st_valid = 1'b0;
        chk("t3_occ_lag", occupancy, 3'd3);
        step();
        chk("t3_occ_back", occupancy, 3'd4);
        snoop_start(32'h0000_4000);
        chk("t3_new_hit", snoop_hit, 1'b1);
        chk("t3_new_dat", snoop_dat, 32'hE0E1_E2E3);
        snoop_end();
        snoop_start(32'h0000_3008);
        chk("t3_old_miss", snoop_hit, 1'b0);
        snoop_end();

        // Store held off during RESPOND, snapshot survives invalidate
        snoop_start(32'h0000_3004);
        st_valid = 1'b1; st_adr = 32'h0000_3000; st_dat = 32'h0000_0055; st_sel = 4'h1;
        inv_valid = 1'b1; inv_adr = 32'h0000_3004;
        #1;
        chk("t4_resp_rdy", st_ready, 1'b0);
        step();
        inv_valid = 1'b0;
        chk("t4_snap_ack", snoop_ack, 1'b1);
        chk("t4_snap_hit", snoop_hit, 1'b1);
        chk("t4_snap_dat", snoop_dat, 32'hB0B1_B2B3);
        snoop_end();
        chk("t4_idle_rdy", st_ready, 1'b1);
        step();
        st_valid = 1'b0;
        step();
        chk("t4_occ", occupancy, 3'd3);
        snoop_start(32'h0000_3000);
        chk("t4_merge_dat", snoop_dat, 32'hA0A1_A255);
        snoop_end();

        // One-cycle snoop pulse aborts in LOOKUP
        snoop_type = 1'b1; snoop_adr = 32'h0000_3000;
        step();
        snoop_type = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_ack", snoop_ack, 1'b0);
        end
        chk("t5_idle_rdy", st_ready, 1'b1);

        // Zero byte-enable store is a no-op
        store(32'h0000_5000, 32'h1234_5678, 4'h0);
        step();
        chk("t5_sel0_occ", occupancy, 3'd3);

        // Store and invalidate to the same word: store rebuilds the entry
        st_valid = 1'b1; st_adr = 32'h0000_300C; st_dat = 32'h0000_7700; st_sel = 4'h2;
        inv_valid = 1'b1; inv_adr = 32'h0000_300C;
        step();
        st_valid = 1'b0; inv_valid = 1'b0;
        snoop_start(32'h0000_300C);
        chk("t5_rebuild_miss", snoop_hit, 1'b0);
        snoop_end();
        store(32'h0000_300C, 32'h1122_0044, 4'hD);
        snoop_start(32'h0000_300C);
        chk("t5_rebuild_hit", snoop_hit, 1'b1);
        chk("t5_rebuild_dat", snoop_dat, 32'h1122_7744);
        snoop_end();

        // Asynchronous reset in RESPOND
        snoop_start(32'h0000_3000);
        chk("t6_pre_hit", snoop_hit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", snoop_ack, 1'b0);
        chk("t6_rst_hit", snoop_hit, 1'b0);
        chk("t6_rst_dat", snoop_dat, 32'h0);
        chk("t6_rst_occ", occupancy, 3'd0);
        snoop_type = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_rel_rdy", st_ready, 1'b1);
        chk("t6_rel_occ", occupancy, 3'd0);
        snoop_start(32'h0000_3000);
        chk("t6_empty_ack", snoop_ack, 1'b1);
        chk("t6_empty_hit", snoop_hit, 1'b0);
        snoop_end();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
